// File: rtl/vga_capture_pkg.sv
// Shared constants and types for the VGA frame capture block.
// Holds the default 640x480 timing, the derived line/frame totals and
// the capture FSM state encoding used by vga_frame_capture.
package vga_capture_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_ADDR_W   = 19;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/vga_sync_tracker.sv
// Recovers raster position from the sampled hsync/vsync stream.
// Ports: clk/reset/pix_en/hsync/vsync in; v_fall (vsync fall on this sample),
//   active/x/y (decode of the current sample), sync_bad (timing violation seen).
// Optional macro VGA_CAPTURE_SYNC_CHECK_EN enables sync_bad and lets h_cnt
//   run one past the line end so an overlong line is visible.
module vga_sync_tracker
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          hsync,
  input  logic          vsync,
  output logic          v_fall,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sync_bad
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_LO   = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] H_HI   = HCW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCW-1:0] V_LO   = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] V_HI   = VCW'(V_SYNC + V_BP + V_ACTIVE);
  // v_cnt parks one past the last line so a missing vsync never re-enters the active band.
  localparam logic [VCW-1:0] V_MAX  = VCW'(V_TOTAL);

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  localparam logic [HCW-1:0] H_MAX  = HCW'(H_TOTAL);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
`else
  localparam logic [HCW-1:0] H_MAX  = H_LAST;
`endif

  logic           hs_q, vs_q;
  logic           h_fall;
  logic [HCW-1:0] h_cnt, h_next;
  logic [VCW-1:0] v_cnt, v_next;

  assign h_fall = pix_en && hs_q && !hsync;
  assign v_fall = pix_en && vs_q && !vsync;

  // Position of the sample being taken this cycle; the falling sample itself is 0.
  always_comb begin
    h_next = h_cnt;
    if (h_fall) begin
      h_next = '0;
    end else if (h_cnt != H_MAX) begin
      h_next = h_cnt + 1'b1;
    end
    v_next = v_cnt;
    if (v_fall) begin
      v_next = '0;
    end else if (h_fall && (v_cnt != V_MAX)) begin
      v_next = v_cnt + 1'b1;
    end
  end

  assign active = pix_en && (h_next >= H_LO) && (h_next < H_HI)
                         && (v_next >= V_LO) && (v_next < V_HI);
  assign x = XW'(h_next - H_LO);
  assign y = YW'(v_next - V_LO);

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  assign sync_bad = (h_fall && (h_cnt != H_LAST))
                 || (pix_en && !h_fall && (h_cnt == H_LAST))
                 || (v_fall && (v_cnt != V_LAST));
`else
  assign sync_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures whole VGA frames from the renderer output into a framebuffer write port.
// Ports: clk/reset, pix_en/pixel/hsync/vsync stream, capture_en request level;
//   wr_en/wr_addr/wr_data write port (one cycle after the sample), frame_done, locked, sync_err.
// Optional macro VGA_CAPTURE_SYNC_CHECK_EN compiles in the sync checker; otherwise sync_err is 0.
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [2:0]        pixel,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_W-1:0] LINE_LEN  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  cap_state_t        state, state_nxt;
  logic              v_fall, active, sync_bad, err_evt, do_write;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] pix_addr;

  vga_sync_tracker #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .XW       (XW),       .YW   (YW)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .hsync    (hsync),
    .vsync    (vsync),
    .v_fall   (v_fall),
    .active   (active),
    .x        (x),
    .y        (y),
    .sync_bad (sync_bad)
  );

  assign pix_addr = ADDR_W'(y) * LINE_LEN + ADDR_W'(x);
  assign err_evt  = (state == CAPTURE) && sync_bad;
  // Dropping capture_en kills the write of the same sample, so a discarded frame ends cleanly.
  assign do_write = (state == CAPTURE) && capture_en && active && !err_evt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_en) state_nxt = ARM;
      ARM: begin
        if (!capture_en)  state_nxt = IDLE;
        else if (v_fall)  state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!capture_en)                         state_nxt = IDLE;
        else if (err_evt)                        state_nxt = ARM;
        else if (wr_en && (wr_addr == LAST_ADDR)) state_nxt = DONE;
      end
      DONE:    state_nxt = capture_en ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign frame_done = (state == DONE);
  assign locked     = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= pix_addr;
        wr_data <= pixel;
      end
    end
  end

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  logic cap_q, err_q;

  // A fresh capture request acknowledges the previous error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cap_q <= capture_en;
      if (capture_en && !cap_q) begin
        err_q <= 1'b0;
      end else if (err_evt) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sync_err = err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
`timescale 1ns/1ps
module tb_vga_frame_capture;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, pix_en, hsync, vsync, capture_en;
  logic [2:0]    pixel;
  logic          wr_en, frame_done, locked, sync_err;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .pixel      (pixel),
    .hsync      (hsync),
    .vsync      (vsync),
    .capture_en (capture_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  typedef struct {
    bit cap;
    bit half;
    bit cpix;
    int frames;
    int exp_wr;
    int exp_done;
    int period;
  } vec_t;

  vec_t vt[4];

  int checks = 0;
  int errors = 0;

  // Raster generator position (H_TOTAL=8, V_TOTAL=6) and behavioural expectations.
  int gh, gv, cyc, wr_cnt, done_cnt, budget, base;
  bit ph, half, cpix, prev_vs, prev_cap, m_cap, m_err, pend, glitch_arm, found;
  int done_t[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; capture_en = 1'b0; pix_en = 1'b0;
    hsync = 1'b1; vsync = 1'b1; pixel = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {wr_en, wr_addr, wr_data, frame_done, locked, sync_err}, 32'd0);
    reset = 1'b0;
    m_cap = 0; m_err = 0; pend = 0; prev_vs = 1; prev_cap = 0; glitch_arm = 0; ph = 0;
    gh = 0; gv = 3; wr_cnt = 0; done_cnt = 0; cyc = 0;
    done_t.delete();
  endtask

  // One clk cycle: drive the next sample, then check outputs 1ns after the edge.
  task automatic cycle();
    logic       s_act, vfall, glitch_now, exp_wr;
    logic [3:0] s_addr;
    logic [2:0] s_pix;
    bit         pe;
    s_act = 0; vfall = 0; glitch_now = 0; s_addr = '0; s_pix = '0;
    ph = ~ph;
    pe = half ? ph : 1'b1;
    pix_en = pe;
    if (pe) begin
      if (glitch_arm && gv == 3 && gh == 6) begin
        gh = 0; gv = 4; glitch_arm = 0; glitch_now = 1;
      end
      hsync  = (gh >= 2);
      vsync  = (gv != 0);
      s_pix  = cpix ? 3'b101 : 3'(gh * 3 + gv);
      pixel  = s_pix;
      s_act  = (gh >= 3 && gh <= 6 && gv >= 2 && gv <= 4);
      s_addr = 4'((gv - 2) * 4 + (gh - 3));
      vfall  = prev_vs && !vsync;
      prev_vs = vsync;
      gh++;
      if (gh == 8) begin
        gh = 0;
        gv = (gv == 5) ? 0 : gv + 1;
      end
    end else begin
      pixel = 3'b010;
    end
    if (capture_en && !prev_cap) m_err = 0;
    prev_cap = capture_en;
    if (!capture_en) m_cap = 0;
    if (glitch_now && m_cap) begin m_err = 1; m_cap = 0; end
    if (vfall && capture_en) m_cap = 1;
    exp_wr = m_cap && s_act;
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_en", wr_en, exp_wr);
    if (wr_en) wr_cnt++;
    if (exp_wr) begin
      chk("wr_addr", wr_addr, s_addr);
      chk("wr_data", wr_data, s_pix);
      chk("locked_in_capture", locked, 1);
    end
    chk("frame_done", frame_done, pend);
    if (frame_done) begin
      done_cnt++;
      done_t.push_back(cyc);
    end
    pend = exp_wr && (s_addr == 4'd11);
    chk("sync_err", sync_err, m_err);
  endtask

  initial begin
    vt[0] = '{cap: 0, half: 0, cpix: 0, frames: 0, exp_wr: 0,  exp_done: 0, period: 0};
    vt[1] = '{cap: 1, half: 0, cpix: 0, frames: 1, exp_wr: 12, exp_done: 1, period: 48};
    vt[2] = '{cap: 1, half: 0, cpix: 0, frames: 3, exp_wr: 36, exp_done: 3, period: 48};
    vt[3] = '{cap: 1, half: 1, cpix: 1, frames: 1, exp_wr: 12, exp_done: 1, period: 96};

    for (int i = 0; i < 4; i++) begin
      half = vt[i].half;
      cpix = vt[i].cpix;
      do_reset();
      repeat (4) cycle();
      capture_en = vt[i].cap;
      if (vt[i].frames == 0) begin
        repeat (150) cycle();
      end else begin
        budget = 1000;
        while (done_cnt < vt[i].frames && budget > 0) begin
          cycle();
          budget--;
        end
      end
      capture_en = 1'b0;
      repeat (6) cycle();
      chk("writes", wr_cnt, vt[i].exp_wr);
      chk("frame_dones", done_cnt, vt[i].exp_done);
      for (int k = 1; k < done_t.size(); k++)
        chk("done_spacing", done_t[k] - done_t[k-1], vt[i].period);
    end

    // capture_en dropped right after address 5 is written.
    half = 0; cpix = 0;
    do_reset();
    repeat (4) cycle();
    capture_en = 1'b1;
    found = 0; budget = 300;
    while (!found && budget > 0) begin
      cycle();
      budget--;
      if (wr_en && wr_addr == 4'd5) found = 1;
    end
    chk("drop_reached_addr5", found, 1);
    capture_en = 1'b0;
    base = wr_cnt;
    cycle();
    chk("drop_locked", locked, 0);
    repeat (100) cycle();
    chk("drop_writes", wr_cnt - base, 0);
    chk("drop_no_done", done_cnt, 0);

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    // Early hsync fall (h_cnt=5) in the middle of a captured frame.
    do_reset();
    repeat (4) cycle();
    capture_en = 1'b1;
    budget = 300;
    while (wr_cnt == 0 && budget > 0) begin
      cycle();
      budget--;
    end
    glitch_arm = 1;
    while (glitch_arm && budget > 0) begin
      cycle();
      budget--;
    end
    chk("err_set", sync_err, 1);
    base = wr_cnt;
    repeat (12) cycle();
    chk("err_writes_stop", wr_cnt - base, 0);
    chk("err_no_done", done_cnt, 0);
    capture_en = 1'b0;
    cycle();
    capture_en = 1'b1;
    cycle();
    chk("err_cleared", sync_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
